mux_stream_arb: RTL



---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_stream_arb_rr_arbiter.sv | 34 +++
 rtl/mux_stream_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer slice: grant-mode encodings,
// default geometry and the helper that locates a channel inside the
// flattened input data bus.
package mux_pkg;

  // Grant-mode encodings for the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Default geometry matches the original 16x16 word multiplexer
  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 16;

  // Lowest bit index of channel ch in a bus of width-bit words packed
  // channel 0 first (channel k lives at [k*width +: width])
  function automatic int chanLsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage : mux_pkg

// File: rtl/mux_stream_arb_rr_arbiter.sv
// Round-robin arbiter for mux_stream_arb. Searches the request vector
// upward starting one past the last granted channel, wrapping modulo
// CHANNELS, so CHANNELS need not be a power of two. Purely combinational;
// the last-grant register lives in the parent.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last_ch,
  input  logic                enable,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  // Walk offsets from farthest to nearest so the channel closest after
  // last_ch is the one left standing when the loop finishes
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx = (int'(last_ch) + off) % CHANNELS;
      if (enable && req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mux_stream_arb.sv
// N-channel stream multiplexer with a single-entry registered output and
// valid/ready handshaking on both sides. Grants come either from the sel
// input (fixed mode) or from a round-robin arbiter.
// Build option: define MUX_STREAM_RR_EN to build the round-robin arbiter
// and honour the mode input; without it the block is fixed-select only.
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  logic               load;
  logic               fixGrantValid;
  logic               grantValid;
  logic [SEL_W-1:0]   grant;
  logic [WIDTH-1:0]   grantData;

  logic               outValid_q, outValid_d;
  logic [WIDTH-1:0]   outData_q,  outData_d;
  logic [SEL_W-1:0]   outCh_q,    outCh_d;

  // The output slot can take a word when it is empty or being drained now
  assign load = !outValid_q || out_ready;

  // Fixed grant is valid only if sel names an existing channel that is
  // currently offering data; an out-of-range sel matches no channel
  always_comb begin
    fixGrantValid = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k) && in_valid[k]) begin
        fixGrantValid = 1'b1;
      end
    end
  end

`ifdef MUX_STREAM_RR_EN
  logic             rrMode;
  logic [SEL_W-1:0] rrGrant;
  logic             rrGrantValid;
  logic [SEL_W-1:0] lastCh_q, lastCh_d;

  assign rrMode = (mode == MODE_RR);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) uArbiter (
    .req         (in_valid),
    .last_ch     (lastCh_q),
    .enable      (rrMode),
    .grant       (rrGrant),
    .grant_valid (rrGrantValid)
  );

  // Pick the grant source for this cycle according to the current mode
  always_comb begin
    grant      = sel;
    grantValid = fixGrantValid;
    if (rrMode) begin
      grant      = rrGrant;
      grantValid = rrGrantValid;
    end
  end

  // Only round-robin handshakes move the fairness pointer
  always_comb begin
    lastCh_d = lastCh_q;
    if (load && grantValid && rrMode) begin
      lastCh_d = grant;
    end
  end

  // Fairness pointer resets to the top channel so channel 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      lastCh_q <= SEL_W'(CHANNELS - 1);
    end else begin
      lastCh_q <= lastCh_d;
    end
  end
`else
  logic unusedMode;
  assign unusedMode = mode;
  assign grant      = sel;
  assign grantValid = fixGrantValid;
`endif

  // Steer the granted channel's word onto the register input
  always_comb begin
    grantData = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        grantData = in_data[chanLsb(k, WIDTH) +: WIDTH];
      end
    end
  end

  // One-hot accept strobe to the granted channel, suppressed during reset
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!rst && load && grantValid && grant == SEL_W'(k)) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  // Output slot: refill on load with a grant, empty on load without one,
  // otherwise hold; data and channel keep their last value when emptied
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    if (load) begin
      if (grantValid) begin
        outValid_d = 1'b1;
        outData_d  = grantData;
        outCh_d    = grant;
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  // Output register; reset discards any pending word
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_ch    = outCh_q;

endmodule : mux_stream_arb
